// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter.
//   req      : per-requester transmit request, held until the matching ack
//   req_data : byte for requester i at [8i+7:8i], stable while req[i] is high
//   gnt      : one-hot grant, high while the requester's byte is in flight
//   ack      : one-cycle completion pulse to the granted requester
//   err      : one-cycle pulse alongside ack when the UART never went busy
// The requesters use the master modport; the arbiter uses the slave modport.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              err;

    modport master (
        output req, req_data,
        input  gnt, ack, err
    );

    modport slave (
        input  req, req_data,
        output gnt, ack, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// One byte is moved per transaction: latch the winner's byte, strobe the
// UART, wait for it to go busy (bounded by BUSY_TIMEOUT), wait for it to go
// idle again, then acknowledge the requester.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : requester handshake (req/req_data in, gnt/ack/err out)
//   uart_tx_start : one-cycle start strobe to the UART transmitter
//   uart_tx_data  : byte to transmit, 0x00 outside a transaction
//   uart_tx_busy  : busy flag from the UART transmitter
//   sent_cnt      : bytes completed without a busy timeout (wraps)
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    bus,
    output logic                uart_tx_start,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_busy,
    output logic [15:0]         sent_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        ACK       = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   sel, sel_d;
    logic [IW-1:0]   last_grant, last_grant_d;
    logic [7:0]      byte_q, byte_d;
    logic [CW-1:0]   tcnt, tcnt_d;
    logic            tflag, tflag_d;
    logic [IW-1:0]   win;
    logic            any;

    logic [NREQ-1:0] gnt_d, ack_d;
    logic            err_d, start_d;
    logic [7:0]      data_d;
    logic [15:0]     cnt_d;

    // State and registered outputs; outputs are loaded from the values the
    // next state will present, so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= '0;
            last_grant    <= IW'(NREQ - 1);
            byte_q        <= 8'h00;
            tcnt          <= '0;
            tflag         <= 1'b0;
            bus.gnt       <= '0;
            bus.ack       <= '0;
            bus.err       <= 1'b0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= 8'h00;
            sent_cnt      <= 16'h0000;
        end else begin
            state         <= state_d;
            sel           <= sel_d;
            last_grant    <= last_grant_d;
            byte_q        <= byte_d;
            tcnt          <= tcnt_d;
            tflag         <= tflag_d;
            bus.gnt       <= gnt_d;
            bus.ack       <= ack_d;
            bus.err       <= err_d;
            uart_tx_start <= start_d;
            uart_tx_data  <= data_d;
            sent_cnt      <= cnt_d;
        end
    end

    // Next-state logic, including the round-robin search from last_grant+1.
    always_comb begin
        int unsigned cand;
        state_d      = state;
        sel_d        = sel;
        last_grant_d = last_grant;
        byte_d       = byte_q;
        tcnt_d       = tcnt;
        tflag_d      = tflag;
        win          = last_grant;
        any          = 1'b0;
        cand         = 0;

        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_grant) + k) % NREQ;
            if (!any && bus.req[IW'(cand)]) begin
                any = 1'b1;
                win = IW'(cand);
            end
        end

        case (state)
            IDLE: begin
                if (any && !uart_tx_busy) begin
                    state_d = START;
                    sel_d   = win;
                    byte_d  = bus.req_data[{win, 3'b000} +: 8];
                    tcnt_d  = '0;
                    tflag_d = 1'b0;
                end
            end
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                // Busy wins over a timeout landing on the same cycle.
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tcnt == CW'(BUSY_TIMEOUT - 1)) begin
                    tflag_d = 1'b1;
                    state_d = ACK;
                end else begin
                    tcnt_d = tcnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d      = IDLE;
                last_grant_d = sel;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the state being entered.
    always_comb begin
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = 1'b0;
        start_d = 1'b0;
        data_d  = 8'h00;
        cnt_d   = sent_cnt;
        case (state_d)
            START: begin
                gnt_d[sel_d] = 1'b1;
                start_d      = 1'b1;
                data_d       = byte_d;
            end
            WAIT_BUSY, WAIT_DONE: begin
                gnt_d[sel_d] = 1'b1;
                data_d       = byte_d;
            end
            ACK: begin
                ack_d[sel_d] = 1'b1;
                err_d        = tflag_d;
                data_d       = byte_d;
                if (!tflag_d) begin
                    cnt_d = sent_cnt + 16'd1;
                end
            end
            default: ;
        endcase
    end

endmodule
